product_accumulator: RTL and testbench



---
 rtl/product_accumulator.sv | 94 +++++++++
 tb/tb_product_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed-length burst of 8-bit products
// into a saturating accumulator, then holds the total until acknowledged.
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc,
    output logic             acc_valid,
    input  logic             acc_ack,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;

    // One extra bit so len = 0 can hold the full 2^CNT_W burst length.
    logic [CNT_W:0]   count;
    logic [CNT_W:0]   count_load;
    logic [ACC_W:0]   sum;
    logic             xfer;
    logic             last;

    assign xfer       = (state == RUN) && prod_valid;
    assign last       = (count == {{CNT_W{1'b0}}, 1'b1});
    assign count_load = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};

    // Sum one bit wider than the accumulator; the top bit flags saturation.
    assign sum = {1'b0, acc} + {{(ACC_W+1-8){1'b0}}, prod};

    // Next-state decode and state-only output decode.
    always_comb begin
        state_nxt  = state;
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                prod_ready = 1'b1;
                busy       = 1'b1;
                if (xfer && last) state_nxt = HOLD;
            end
            HOLD: begin
                acc_valid = 1'b1;
                busy      = 1'b1;
                if (acc_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Accumulator, sticky overflow and remaining-count datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (state == IDLE && start) begin
            acc      <= '0;
            overflow <= 1'b0;
            count    <= count_load;
        end else if (xfer) begin
            count <= count - 1'b1;
            if (sum[ACC_W]) begin
                acc      <= {ACC_W{1'b1}};
                overflow <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default-width instance and a
// 10-bit-accumulator instance share one stimulus stream.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic [7:0] prod = '0;
    logic       prod_valid = 1'b0;
    logic       acc_ack = 1'b0;

    logic        d_ready, d_valid, d_ovf, d_busy;
    logic [11:0] d_acc;
    logic        s_ready, s_valid, s_ovf, s_busy;
    logic [9:0]  s_acc;

    int tests = 0;
    int fails = 0;
    bit flag;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(12), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(d_ready), .acc(d_acc),
        .acc_valid(d_valid), .acc_ack(acc_ack), .overflow(d_ovf), .busy(d_busy)
    );

    product_accumulator #(.ACC_W(10), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(s_ready), .acc(s_acc),
        .acc_valid(s_valid), .acc_ack(acc_ack), .overflow(s_ovf), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3 rst_n = 1'b0;
        #1;
        chk("rst_acc", {20'd0, d_acc}, 0);
        chk("rst_outs", {d_valid, d_ready, d_busy, d_ovf}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_outs", {d_valid, d_ready, d_busy, d_ovf}, 0);

        // Basic burst: 225 + 1 + 100
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        chk("run_ready", {d_ready, d_busy, d_valid}, 3'b110);
        prod_valid = 1'b1; prod = 8'd225;
        tick();
        chk("basic_acc1", {20'd0, d_acc}, 225);
        prod = 8'd1;
        tick();
        chk("basic_acc2", {20'd0, d_acc}, 226);
        chk("basic_novalid", {31'd0, d_valid}, 0);
        prod = 8'd100;
        tick();
        prod_valid = 1'b0;
        chk("basic_acc3", {20'd0, d_acc}, 326);
        chk("basic_hold", {d_valid, d_ready, d_ovf}, 3'b100);
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
        chk("ack_idle", {d_valid, d_busy}, 0);
        chk("ack_keep", {20'd0, d_acc}, 326);

        // Length wrap: len = 0 means 16 transfers
        start = 1'b1; len = 4'd0;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod = 8'd225;
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (d_valid) flag = 1'b1;
        end
        chk("wrap_early_valid", {31'd0, flag}, 0);
        chk("wrap_acc15", {20'd0, d_acc}, 3375);
        tick();
        prod_valid = 1'b0;
        chk("wrap_acc16", {20'd0, d_acc}, 3600);
        chk("wrap_valid", {31'd0, d_valid}, 1);
        chk("wrap_sat10", {21'd0, s_ovf, s_acc}, {1'b1, 10'd1023});
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;

        // Saturation on the 10-bit instance
        start = 1'b1; len = 4'd5;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod = 8'd225;
        tick(); tick(); tick(); tick();
        chk("sat_acc4", {21'd0, s_ovf, s_acc}, {1'b0, 10'd900});
        tick();
        prod_valid = 1'b0;
        chk("sat_acc5", {21'd0, s_ovf, s_acc}, {1'b1, 10'd1023});
        chk("sat_wide", {19'd0, d_ovf, d_acc}, {1'b0, 12'd1125});
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
        chk("sat_idle_keep", {21'd0, s_ovf, s_acc}, {1'b1, 10'd1023});
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        chk("sat_clear", {21'd0, s_ovf, s_acc}, 0);
        prod_valid = 1'b1; prod = 8'd7;
        tick();
        prod_valid = 1'b0;
        chk("sat_new", {20'd0, s_valid, s_ovf, s_acc}, {1'b1, 1'b0, 10'd7});
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;

        // Backpressure, ignored start/ack in RUN, ignored start in HOLD
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod = 8'd10;
        tick();
        prod_valid = 1'b0;
        tick();
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0; acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
        tick();
        chk("gap_acc", {20'd0, d_acc}, 10);
        chk("gap_run", {d_ready, d_busy, d_valid}, 3'b110);
        prod_valid = 1'b1; prod = 8'd20;
        tick();
        prod_valid = 1'b0;
        chk("bp_acc", {20'd0, d_acc}, 30);
        start = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            if (!d_valid || d_acc != 12'd30 || d_ready) flag = 1'b1;
        end
        chk("hold_stable", {31'd0, flag}, 0);
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
        chk("bp_idle", {d_valid, d_busy, d_ready}, 0);

        // start and prod_valid together in IDLE: no transfer that cycle
        start = 1'b1; len = 4'd1; prod_valid = 1'b1; prod = 8'd50;
        #1;
        chk("idle_noready", {31'd0, d_ready}, 0);
        tick();
        start = 1'b0;
        chk("idle_noxfer", {19'd0, d_valid, d_acc}, 0);
        tick();
        prod_valid = 1'b0;
        chk("idle_then_xfer", {19'd0, d_valid, d_acc}, {1'b1, 12'd50});
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;

        // Reset mid-burst
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod = 8'd3;
        tick(); tick();
        prod_valid = 1'b0;
        chk("mid_acc", {20'd0, d_acc}, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst", {d_valid, d_ready, d_busy, d_ovf, d_acc}, 0);
        chk("mid_rst_sat", {s_valid, s_ready, s_busy, s_ovf, s_acc}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod = 8'd9;
        tick();
        prod_valid = 1'b0;
        chk("post_rst", {19'd0, d_valid, d_acc}, {1'b1, 12'd9});
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
